// File: rtl/washer_plant_model.sv
// washer_plant_model
//   Behavioural plant and sensor model for the washing-machine controller.
//   Turns actuator commands into water-level, timer and dispenser feedback,
//   and latches a sticky fault on illegal command combinations.
//
// Ports
//   Clock            in   system clock, rising-edge active
//   Reset            in   asynchronous active-low reset
//   Motor_on         in   drum motor command
//   Fill_valve_on    in   fill valve command
//   Drained_valve_on in   drain valve command
//   Door_Lock        in   door lock command
//   Done             in   wash-complete pulse from the controller
//   Filled           out  level at LEVEL_MAX
//   Drained          out  level at zero
//   Detergent_Added  out  dispenser has finished
//   Cycle_Timeout    out  wash timer expired
//   Spin_Timeout     out  spin timer expired
//   Water_Level      out  current water level
//   Wash_Count       out  completed washes (wraps)
//   Fault            out  sticky illegal-command flag
//
// Every output comes from a register or a decode of one, so the
// controller's combinational outputs never loop back combinationally.
module washer_plant_model #(
  parameter int LEVEL_W     = 8,
  parameter int LEVEL_MAX   = 200,
  parameter int FILL_RATE   = 5,
  parameter int DRAIN_RATE  = 8,
  parameter int CNT_W       = 16,
  parameter int CYCLE_TICKS = 1000,
  parameter int SPIN_TICKS  = 500,
  parameter int DET_TICKS   = 20
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Motor_on,
  input  logic               Fill_valve_on,
  input  logic               Drained_valve_on,
  input  logic               Door_Lock,
  input  logic               Done,
  output logic               Filled,
  output logic               Drained,
  output logic               Detergent_Added,
  output logic               Cycle_Timeout,
  output logic               Spin_Timeout,
  output logic [LEVEL_W-1:0] Water_Level,
  output logic [7:0]         Wash_Count,
  output logic               Fault
);

  localparam logic [LEVEL_W-1:0] LVL_FULL  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W:0]   FILL_INC  = (LEVEL_W+1)'(FILL_RATE);
  localparam logic [LEVEL_W-1:0] DRAIN_DEC = LEVEL_W'(DRAIN_RATE);
  localparam logic [CNT_W-1:0]   CYC_LAST  = CNT_W'(CYCLE_TICKS);
  localparam logic [CNT_W-1:0]   SPIN_LAST = CNT_W'(SPIN_TICKS);
  localparam logic [CNT_W-1:0]   DET_LAST  = CNT_W'(DET_TICKS - 1);

  typedef enum logic [1:0] {
    DET_IDLE,
    DET_WAIT,
    DET_ADDED
  } det_state_e;

  logic [LEVEL_W-1:0] level_q,    level_d;
  logic [CNT_W-1:0]   cyc_cnt_q,  cyc_cnt_d;
  logic [CNT_W-1:0]   spin_cnt_q, spin_cnt_d;
  logic [CNT_W-1:0]   det_cnt_q,  det_cnt_d;
  det_state_e         det_state_q, det_state_d;
  logic [7:0]         wash_cnt_q, wash_cnt_d;
  logic               fault_q,    fault_d;

  logic [LEVEL_W:0]   fill_sum;
  logic               filled_w;
  logic               drained_w;
  logic               ready_w;

  assign filled_w  = (level_q == LVL_FULL);
  assign drained_w = (level_q == '0);
  assign ready_w   = Door_Lock & filled_w & ~Motor_on & ~Fill_valve_on & ~Drained_valve_on;

  // Level register; the sum is one bit wider so a fill near the top cannot wrap.
  always_comb begin
    fill_sum = {1'b0, level_q} + FILL_INC;
    level_d  = level_q;
    if (Fill_valve_on && !Drained_valve_on) begin
      if (fill_sum >= {1'b0, LVL_FULL}) level_d = LVL_FULL;
      else                              level_d = fill_sum[LEVEL_W-1:0];
    end else if (Drained_valve_on && !Fill_valve_on) begin
      if (level_q > DRAIN_DEC) level_d = level_q - DRAIN_DEC;
      else                     level_d = '0;
    end
  end

  // Wash and spin timers. Spin qualifies on the registered Drained, so the
  // controller's final drain edge (level already 0) is the first counted one.
  always_comb begin
    cyc_cnt_d = '0;
    if (Motor_on) begin
      cyc_cnt_d = (cyc_cnt_q == CYC_LAST) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
    end
    spin_cnt_d = '0;
    if (Drained_valve_on && Door_Lock && drained_w) begin
      spin_cnt_d = (spin_cnt_q == SPIN_LAST) ? spin_cnt_q : spin_cnt_q + 1'b1;
    end
  end

  // Dispenser: the IDLE->WAIT edge is the first of DET_TICKS counted edges,
  // so WAIT exits when the incremented count reaches DET_TICKS-1.
  always_comb begin
    det_state_d = det_state_q;
    det_cnt_d   = det_cnt_q;
    unique case (det_state_q)
      DET_IDLE: begin
        if (ready_w) begin
          det_cnt_d   = '0;
          det_state_d = (DET_TICKS == 1) ? DET_ADDED : DET_WAIT;
        end
      end
      DET_WAIT: begin
        if (!ready_w) begin
          det_state_d = DET_IDLE;
        end else begin
          det_cnt_d = det_cnt_q + 1'b1;
          if (det_cnt_q + 1'b1 == DET_LAST) det_state_d = DET_ADDED;
        end
      end
      DET_ADDED: begin
        if (!Door_Lock) det_state_d = DET_IDLE;
      end
      default: det_state_d = DET_IDLE;
    endcase
  end

  always_comb begin
    wash_cnt_d = Done ? wash_cnt_q + 8'd1 : wash_cnt_q;
    fault_d    = fault_q
               | (Fill_valve_on & Drained_valve_on)
               | (Motor_on & ~Door_Lock)
               | (~Door_Lock & ~drained_w);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      level_q     <= '0;
      cyc_cnt_q   <= '0;
      spin_cnt_q  <= '0;
      det_cnt_q   <= '0;
      det_state_q <= DET_IDLE;
      wash_cnt_q  <= '0;
      fault_q     <= 1'b0;
    end else begin
      level_q     <= level_d;
      cyc_cnt_q   <= cyc_cnt_d;
      spin_cnt_q  <= spin_cnt_d;
      det_cnt_q   <= det_cnt_d;
      det_state_q <= det_state_d;
      wash_cnt_q  <= wash_cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign Filled          = filled_w;
  assign Drained         = drained_w;
  assign Detergent_Added = (det_state_q == DET_ADDED);
  assign Cycle_Timeout   = (cyc_cnt_q == CYC_LAST);
  assign Spin_Timeout    = (spin_cnt_q == SPIN_LAST);
  assign Water_Level     = level_q;
  assign Wash_Count      = wash_cnt_q;
  assign Fault           = fault_q;

endmodule

// File: tb/tb_washer_plant_model.sv
module tb_washer_plant_model;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock, Done;
  logic       Filled, Drained, Detergent_Added, Cycle_Timeout, Spin_Timeout;
  logic [7:0] Water_Level;
  logic [7:0] Wash_Count;
  logic       Fault;

  int total = 0;
  int bad   = 0;

  washer_plant_model #(
    .LEVEL_W    (8),
    .LEVEL_MAX  (8),
    .FILL_RATE  (3),
    .DRAIN_RATE (3),
    .CNT_W      (16),
    .CYCLE_TICKS(4),
    .SPIN_TICKS (2),
    .DET_TICKS  (3)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Motor_on        (Motor_on),
    .Fill_valve_on   (Fill_valve_on),
    .Drained_valve_on(Drained_valve_on),
    .Door_Lock       (Door_Lock),
    .Done            (Done),
    .Filled          (Filled),
    .Drained         (Drained),
    .Detergent_Added (Detergent_Added),
    .Cycle_Timeout   (Cycle_Timeout),
    .Spin_Timeout    (Spin_Timeout),
    .Water_Level     (Water_Level),
    .Wash_Count      (Wash_Count),
    .Fault           (Fault)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic m, f, d, l, dn;
  } in_t;

  typedef struct packed {
    logic [7:0] level;
    logic       filled, drained, det, cto, sto;
    logic [7:0] wash;
    logic       fault;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  out_t exp_q[$];
  vec_t tbl[24];

  function automatic vec_t mk(logic m, logic f, logic d, logic l, logic dn,
                              logic [7:0] lvl, logic fl, logic dr, logic det,
                              logic cto, logic sto, logic [7:0] w, logic flt);
    vec_t v;
    v.i = '{m: m, f: f, d: d, l: l, dn: dn};
    v.o = '{level: lvl, filled: fl, drained: dr, det: det, cto: cto, sto: sto,
            wash: w, fault: flt};
    return v;
  endfunction

  function automatic out_t sample();
    out_t s;
    s = '{level: Water_Level, filled: Filled, drained: Drained, det: Detergent_Added,
          cto: Cycle_Timeout, sto: Spin_Timeout, wash: Wash_Count, fault: Fault};
    return s;
  endfunction

  task automatic check(string name, out_t got, out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got lvl=%0d fl=%b dr=%b det=%b cto=%b sto=%b wash=%0d flt=%b ; want lvl=%0d fl=%b dr=%b det=%b cto=%b sto=%b wash=%0d flt=%b",
               name, got.level, got.filled, got.drained, got.det, got.cto, got.sto, got.wash, got.fault,
               exp.level, exp.filled, exp.drained, exp.det, exp.cto, exp.sto, exp.wash, exp.fault);
    end
  endtask

  task automatic drive(in_t i);
    Motor_on         = i.m;
    Fill_valve_on    = i.f;
    Drained_valve_on = i.d;
    Door_Lock        = i.l;
    Done             = i.dn;
  endtask

  // Drive one cycle of commands, queue what the plant must show after the edge.
  task automatic step(string name, in_t i, out_t o);
    out_t e;
    drive(i);
    exp_q.push_back(o);
    @(posedge Clock);
    #1;
    e = exp_q.pop_front();
    check(name, sample(), e);
  endtask

  task automatic do_reset();
    drive('0);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  localparam out_t RST_OUT = '{level: 8'd0, filled: 1'b0, drained: 1'b1, det: 1'b0,
                               cto: 1'b0, sto: 1'b0, wash: 8'd0, fault: 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            m f d l dn  lvl fl dr det cto sto wash flt
    tbl[0]  = mk(0,1,0,1,0,  3, 0,0,0,0,0, 0,0);
    tbl[1]  = mk(0,1,0,1,0,  6, 0,0,0,0,0, 0,0);
    tbl[2]  = mk(0,1,0,1,0,  8, 1,0,0,0,0, 0,0);
    tbl[3]  = mk(0,1,0,1,0,  8, 1,0,0,0,0, 0,0);
    tbl[4]  = mk(0,0,0,1,0,  8, 1,0,0,0,0, 0,0);
    tbl[5]  = mk(0,0,0,1,0,  8, 1,0,0,0,0, 0,0);
    tbl[6]  = mk(0,0,0,1,0,  8, 1,0,1,0,0, 0,0);
    tbl[7]  = mk(1,0,0,1,0,  8, 1,0,1,0,0, 0,0);
    tbl[8]  = mk(1,0,0,1,0,  8, 1,0,1,0,0, 0,0);
    tbl[9]  = mk(0,0,0,1,0,  8, 1,0,1,0,0, 0,0);
    tbl[10] = mk(1,0,0,1,0,  8, 1,0,1,0,0, 0,0);
    tbl[11] = mk(1,0,0,1,0,  8, 1,0,1,0,0, 0,0);
    tbl[12] = mk(1,0,0,1,0,  8, 1,0,1,0,0, 0,0);
    tbl[13] = mk(1,0,0,1,0,  8, 1,0,1,1,0, 0,0);
    tbl[14] = mk(1,0,0,1,0,  8, 1,0,1,1,0, 0,0);
    tbl[15] = mk(0,0,1,1,0,  5, 0,0,1,0,0, 0,0);
    tbl[16] = mk(0,0,1,1,0,  2, 0,0,1,0,0, 0,0);
    tbl[17] = mk(0,0,1,1,0,  0, 0,1,1,0,0, 0,0);
    tbl[18] = mk(0,0,1,1,0,  0, 0,1,1,0,0, 0,0);
    tbl[19] = mk(0,0,1,1,0,  0, 0,1,1,0,1, 0,0);
    tbl[20] = mk(0,0,1,1,0,  0, 0,1,1,0,1, 0,0);
    tbl[21] = mk(0,0,0,1,1,  0, 0,1,1,0,0, 1,0);
    tbl[22] = mk(0,0,0,0,0,  0, 0,1,0,0,0, 1,0);
    tbl[23] = mk(0,0,0,0,0,  0, 0,1,0,0,0, 1,0);

    drive('0);
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    check("reset_state", sample(), RST_OUT);

    for (int k = 0; k < 24; k++) begin
      step($sformatf("row%0d", k), tbl[k].i, tbl[k].o);
    end

    // Asynchronous reset in the middle of a fill, observed before any edge.
    step("midfill_a", '{m:0, f:1, d:0, l:1, dn:0}, mk(0,0,0,0,0, 3,0,0,0,0,0, 1,0).o);
    step("midfill_b", '{m:0, f:1, d:0, l:1, dn:0}, mk(0,0,0,0,0, 6,0,0,0,0,0, 1,0).o);
    #2;
    Reset = 1'b0;
    #1;
    check("async_reset", sample(), RST_OUT);
    drive('0);
    @(posedge Clock);
    #1;
    check("held_reset", sample(), RST_OUT);
    Reset = 1'b1;

    // Both valves: fault next edge, level holds, fault is sticky.
    step("fault_pre",  '{m:0, f:1, d:0, l:1, dn:0}, mk(0,0,0,0,0, 3,0,0,0,0,0, 0,0).o);
    step("fault_both", '{m:0, f:1, d:1, l:1, dn:0}, mk(0,0,0,0,0, 3,0,0,0,0,0, 0,1).o);
    step("fault_stk1", '{m:0, f:0, d:0, l:1, dn:0}, mk(0,0,0,0,0, 3,0,0,0,0,0, 0,1).o);
    step("fault_stk2", '{m:0, f:0, d:1, l:1, dn:0}, mk(0,0,0,0,0, 0,0,1,0,0,0, 0,1).o);
    do_reset();
    check("reset2", sample(), RST_OUT);

    // Motor while unlocked with an empty drum.
    step("motor_unlk", '{m:1, f:0, d:0, l:0, dn:0}, mk(0,0,0,0,0, 0,0,1,0,0,0, 0,1).o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
